// File: rtl/pio_svc_pkg.sv
// Shared types for the pushbutton PIO service controller: FSM states and
// PIO register map.
package pio_svc_pkg;

  typedef enum logic [2:0] {
    S_INIT_MASK = 3'd0,
    S_INIT_CLR  = 3'd1,
    S_IDLE      = 3'd2,
    S_RD_ADDR   = 3'd3,
    S_RD_CAP    = 3'd4,
    S_CLR       = 3'd5,
    S_HOLDOFF   = 3'd6,
    S_REARM     = 3'd7
  } svc_state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/holdoff_timer.sv
// Debounce lockout down-counter: load to HOLDOFF_CYCLES-1, count down to zero
// and hold there.
module holdoff_timer #(
  parameter int unsigned HOLDOFF_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int unsigned CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLDOFF_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pio_button_service_ctrl.sv
// Hardware sequencer for a single-bit pushbutton PIO: arms the irq mask, then
// services each press (read pin, clear capture, debounce lockout, re-arm).
module pio_button_service_ctrl
  import pio_svc_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 500000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_level,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             busy,
  output svc_state_e       dbg_state
);

  svc_state_e       r_state;
  svc_state_e       w_nxt;
  logic [1:0]       r_address;
  logic             r_cs;
  logic             r_write_n;
  logic [31:0]      r_wdata;
  logic             r_busy;
  logic             r_level;
  logic             r_evt_valid;
  logic             r_evt_level;
  logic [CNT_W-1:0] r_evt_count;
  logic             r_overflow;
  logic [1:0]       w_addr;
  logic             w_cs;
  logic             w_write_n;
  logic [31:0]      w_wdata;
  logic             w_hold_load;
  logic             w_hold_dec;
  logic             w_hold_zero;
  logic             w_publish_ok;
  logic             w_mask_wr_seen;
  logic             w_unused_rd;

  assign w_unused_rd = ^pio_readdata[31:1];

  holdoff_timer #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_load (w_hold_load),
    .i_dec  (w_hold_dec),
    .o_zero (w_hold_zero)
  );

  assign w_hold_load = (r_state == S_CLR);
  assign w_hold_dec  = (r_state == S_HOLDOFF);

  // Bus outputs are registered from the next state, so each state's access is
  // on the bus while the FSM sits in that state. Out of reset the bus is idle,
  // so INIT_MASK stays until its own write is visible.
  assign w_mask_wr_seen = r_cs && !r_write_n && (r_address == ADDR_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT_MASK;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_INIT_MASK: if (w_mask_wr_seen) w_nxt = S_INIT_CLR;
      S_INIT_CLR:  w_nxt = S_IDLE;
      S_IDLE:      if (pio_irq && enable) w_nxt = S_RD_ADDR;
      S_RD_ADDR:   w_nxt = S_RD_CAP;
      S_RD_CAP:    w_nxt = S_CLR;
      S_CLR:       w_nxt = S_HOLDOFF;
      S_HOLDOFF:   if (w_hold_zero) w_nxt = S_REARM;
      S_REARM:     w_nxt = S_IDLE;
      default:     w_nxt = S_INIT_MASK;
    endcase
  end

  always_comb begin
    w_addr    = ADDR_DATA;
    w_cs      = 1'b0;
    w_write_n = 1'b1;
    w_wdata   = 32'd0;
    case (w_nxt)
      S_INIT_MASK: begin
        w_addr    = ADDR_MASK;
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_wdata   = 32'd1;
      end
      S_INIT_CLR, S_CLR, S_REARM: begin
        w_addr    = ADDR_EDGE;
        w_cs      = 1'b1;
        w_write_n = 1'b0;
      end
      S_RD_ADDR: begin
        w_addr = ADDR_DATA;
        w_cs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_address <= ADDR_DATA;
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      r_wdata   <= 32'd0;
      r_busy    <= 1'b1;
    end else begin
      r_address <= w_addr;
      r_cs      <= w_cs;
      r_write_n <= w_write_n;
      r_wdata   <= w_wdata;
      r_busy    <= (w_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 1'b0;
    end else if (r_state == S_RD_CAP) begin
      r_level <= pio_readdata[0];
    end
  end

  // Event handshake: an event is transferred on any cycle where evt_valid and
  // evt_ready are both high; evt_valid/evt_level are held stable until then.
  // A publish that would overwrite an untaken event is dropped and flagged.
  assign w_publish_ok = !r_evt_valid || evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_valid <= 1'b0;
      r_evt_level <= 1'b0;
      r_evt_count <= '0;
      r_overflow  <= 1'b0;
    end else if ((r_state == S_CLR) && w_publish_ok) begin
      r_evt_valid <= 1'b1;
      r_evt_level <= r_level;
      r_evt_count <= r_evt_count + CNT_W'(1);
    end else begin
      if (r_state == S_CLR) begin
        r_overflow <= 1'b1;
      end
      if (r_evt_valid && evt_ready) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign pio_address    = r_address;
  assign pio_chipselect = r_cs;
  assign pio_write_n    = r_write_n;
  assign pio_writedata  = r_wdata;
  assign evt_valid      = r_evt_valid;
  assign evt_level      = r_evt_level;
  assign evt_count      = r_evt_count;
  assign overflow       = r_overflow;
  assign busy           = r_busy;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_pio_button_service_ctrl.sv
// Directed bench for pio_button_service_ctrl against a behavioural PIO model
// with registered readdata; a second instance exercises a 2-bit event counter.
module tb_pio_button_service_ctrl;
  import pio_svc_pkg::*;

  localparam logic [35:0] BUS_IDLE    = {1'b0, 1'b1, 2'd0, 32'd0};
  localparam logic [35:0] BUS_WR_MASK = {1'b1, 1'b0, 2'd2, 32'd1};
  localparam logic [35:0] BUS_WR_EDGE = {1'b1, 1'b0, 2'd3, 32'd0};
  localparam logic [35:0] BUS_RD_DATA = {1'b1, 1'b1, 2'd0, 32'd0};

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // instance a (CNT_W=16)
  logic        enable_a, evt_ready_a, pin_a;
  logic [1:0]  pio_address_a;
  logic        pio_chipselect_a, pio_write_n_a;
  logic [31:0] pio_writedata_a, pio_readdata_a;
  logic        pio_irq_a, evt_valid_a, evt_level_a, overflow_a, busy_a;
  logic [15:0] evt_count_a;
  svc_state_e  dbg_state_a;
  logic        pin_d_a, cap_a, mask_a;
  logic [35:0] bus_a;

  // instance b (CNT_W=2)
  logic        enable_b, evt_ready_b, pin_b;
  logic [1:0]  pio_address_b;
  logic        pio_chipselect_b, pio_write_n_b;
  logic [31:0] pio_writedata_b, pio_readdata_b;
  logic        pio_irq_b, evt_valid_b, evt_level_b, overflow_b, busy_b;
  logic [1:0]  evt_count_b;
  svc_state_e  dbg_state_b;
  logic        pin_d_b, cap_b, mask_b;

  logic [1:0] exp_q[$];

  assign bus_a = {pio_chipselect_a, pio_write_n_a, pio_address_a, pio_writedata_a};

  pio_button_service_ctrl #(.HOLDOFF_CYCLES(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable_a),
    .pio_address(pio_address_a), .pio_chipselect(pio_chipselect_a),
    .pio_write_n(pio_write_n_a), .pio_writedata(pio_writedata_a),
    .pio_readdata(pio_readdata_a), .pio_irq(pio_irq_a),
    .evt_valid(evt_valid_a), .evt_ready(evt_ready_a), .evt_level(evt_level_a),
    .evt_count(evt_count_a), .overflow(overflow_a), .busy(busy_a),
    .dbg_state(dbg_state_a)
  );

  pio_button_service_ctrl #(.HOLDOFF_CYCLES(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable_b),
    .pio_address(pio_address_b), .pio_chipselect(pio_chipselect_b),
    .pio_write_n(pio_write_n_b), .pio_writedata(pio_writedata_b),
    .pio_readdata(pio_readdata_b), .pio_irq(pio_irq_b),
    .evt_valid(evt_valid_b), .evt_ready(evt_ready_b), .evt_level(evt_level_b),
    .evt_count(evt_count_b), .overflow(overflow_b), .busy(busy_b),
    .dbg_state(dbg_state_b)
  );

  // PIO models: rising-edge capture, irq mask, readdata registered from address
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_d_a <= 1'b0; cap_a <= 1'b0; mask_a <= 1'b0; pio_readdata_a <= 32'd0;
    end else begin
      pin_d_a <= pin_a;
      case (pio_address_a)
        2'd0:    pio_readdata_a <= {31'd0, pin_a};
        2'd2:    pio_readdata_a <= {31'd0, mask_a};
        2'd3:    pio_readdata_a <= {31'd0, cap_a};
        default: pio_readdata_a <= 32'd0;
      endcase
      if (pio_chipselect_a && !pio_write_n_a && pio_address_a == 2'd2) mask_a <= pio_writedata_a[0];
      if (pio_chipselect_a && !pio_write_n_a && pio_address_a == 2'd3) cap_a <= 1'b0;
      else if (pin_a && !pin_d_a) cap_a <= 1'b1;
    end
  end
  assign pio_irq_a = cap_a & mask_a;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_d_b <= 1'b0; cap_b <= 1'b0; mask_b <= 1'b0; pio_readdata_b <= 32'd0;
    end else begin
      pin_d_b <= pin_b;
      case (pio_address_b)
        2'd0:    pio_readdata_b <= {31'd0, pin_b};
        2'd2:    pio_readdata_b <= {31'd0, mask_b};
        2'd3:    pio_readdata_b <= {31'd0, cap_b};
        default: pio_readdata_b <= 32'd0;
      endcase
      if (pio_chipselect_b && !pio_write_n_b && pio_address_b == 2'd2) mask_b <= pio_writedata_b[0];
      if (pio_chipselect_b && !pio_write_n_b && pio_address_b == 2'd3) cap_b <= 1'b0;
      else if (pin_b && !pin_d_b) cap_b <= 1'b1;
    end
  end
  assign pio_irq_b = cap_b & mask_b;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pin_a = 1'b0;
    pin_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_checks++; if (bus_a !== BUS_IDLE) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", bus_a, BUS_IDLE); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy_a); end
    n_checks++; if ({evt_valid_a, evt_level_a, overflow_a} !== 3'b000) begin n_fail++; $display("FAIL reset_evt: got %b expected 000", {evt_valid_a, evt_level_a, overflow_a}); end
    n_checks++; if (evt_count_a !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", evt_count_a); end
    n_checks++; if (dbg_state_a !== S_INIT_MASK) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state_a, S_INIT_MASK); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    n_checks++; if (bus_a !== BUS_WR_MASK) begin n_fail++; $display("FAIL init_mask_wr: got %h expected %h", bus_a, BUS_WR_MASK); end
    tick();
    n_checks++; if (bus_a !== BUS_WR_EDGE) begin n_fail++; $display("FAIL init_clr_wr: got %h expected %h", bus_a, BUS_WR_EDGE); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL init_busy: got %b expected 1", busy_a); end
    tick();
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL init_idle_busy: got %b expected 0", busy_a); end
    n_checks++; if (bus_a !== BUS_IDLE) begin n_fail++; $display("FAIL init_idle_bus: got %h expected %h", bus_a, BUS_IDLE); end
    n_checks++; if ({evt_valid_a, evt_count_a} !== 17'd0) begin n_fail++; $display("FAIL init_evt: got %h expected 0", {evt_valid_a, evt_count_a}); end
  endtask

  task automatic test_press_bounce();
    do_reset();
    enable_a = 1'b1;
    evt_ready_a = 1'b1;
    pin_a = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 1) begin
        n_checks++; if (pio_irq_a !== 1'b1) begin n_fail++; $display("FAIL press_irq: got %b expected 1", pio_irq_a); end
      end
      if (n == 2) begin
        n_checks++; if (bus_a !== BUS_RD_DATA) begin n_fail++; $display("FAIL press_read: got %h expected %h", bus_a, BUS_RD_DATA); end
      end
      if (n == 4) begin
        n_checks++; if (bus_a !== BUS_WR_EDGE) begin n_fail++; $display("FAIL press_clr: got %h expected %h", bus_a, BUS_WR_EDGE); end
        n_checks++; if (evt_valid_a !== 1'b0) begin n_fail++; $display("FAIL press_early_valid: got %b expected 0", evt_valid_a); end
      end
      if (n == 5) begin
        n_checks++; if ({evt_valid_a, evt_level_a} !== 2'b11) begin n_fail++; $display("FAIL press_evt: got %b expected 11", {evt_valid_a, evt_level_a}); end
        n_checks++; if (evt_count_a !== 16'd1) begin n_fail++; $display("FAIL press_count: got %0d expected 1", evt_count_a); end
        n_checks++; if (pio_irq_a !== 1'b0) begin n_fail++; $display("FAIL press_irq_cleared: got %b expected 0", pio_irq_a); end
      end
      if (n == 6) begin
        n_checks++; if (evt_valid_a !== 1'b0) begin n_fail++; $display("FAIL press_consumed: got %b expected 0", evt_valid_a); end
      end
      if (n >= 5 && n <= 12) begin
        n_checks++; if (bus_a !== BUS_IDLE) begin n_fail++; $display("FAIL holdoff_bus n=%0d: got %h expected %h", n, bus_a, BUS_IDLE); end
      end
      if (n == 11) begin
        n_checks++; if (pio_irq_a !== 1'b1) begin n_fail++; $display("FAIL bounce_captured: got %b expected 1", pio_irq_a); end
      end
      if (n == 13) begin
        n_checks++; if (bus_a !== BUS_WR_EDGE) begin n_fail++; $display("FAIL rearm_wr: got %h expected %h", bus_a, BUS_WR_EDGE); end
      end
      if (n == 14) begin
        n_checks++; if (dbg_state_a !== S_IDLE) begin n_fail++; $display("FAIL back_idle: got %0d expected %0d", dbg_state_a, S_IDLE); end
        n_checks++; if ({busy_a, pio_irq_a} !== 2'b00) begin n_fail++; $display("FAIL back_idle_flags: got %b expected 00", {busy_a, pio_irq_a}); end
        n_checks++; if (evt_count_a !== 16'd1) begin n_fail++; $display("FAIL bounce_count: got %0d expected 1", evt_count_a); end
      end
      if (n >= 5 && n <= 10) pin_a = ~pin_a;
    end
    pin_a = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    do_reset();
    enable_a = 1'b1;
    evt_ready_a = 1'b0;
    pin_a = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      tick();
      if (n == 5) begin
        n_checks++; if ({evt_valid_a, evt_level_a, overflow_a} !== 3'b110) begin n_fail++; $display("FAIL ovf_first: got %b expected 110", {evt_valid_a, evt_level_a, overflow_a}); end
      end
      if (n == 26) begin
        n_checks++; if (overflow_a !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow_a); end
        n_checks++; if ({evt_valid_a, evt_level_a} !== 2'b11) begin n_fail++; $display("FAIL ovf_held: got %b expected 11", {evt_valid_a, evt_level_a}); end
        n_checks++; if (evt_count_a !== 16'd1) begin n_fail++; $display("FAIL ovf_count: got %0d expected 1", evt_count_a); end
      end
      if (n == 28) begin
        n_checks++; if (evt_valid_a !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b expected 0", evt_valid_a); end
        n_checks++; if ({overflow_a, evt_count_a} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL ovf_sticky: got %h expected %h", {overflow_a, evt_count_a}, {1'b1, 16'd1}); end
        evt_ready_a = 1'b0;
      end
      if (n == 6)  pin_a = 1'b0;
      if (n == 20) pin_a = 1'b1;
      if (n == 21) pin_a = 1'b0;
      if (n == 27) evt_ready_a = 1'b1;
    end
    repeat (10) tick();
  endtask

  task automatic test_enable();
    do_reset();
    enable_a = 1'b0;
    evt_ready_a = 1'b1;
    pin_a = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_checks++; if (bus_a !== BUS_IDLE) begin n_fail++; $display("FAIL disabled_bus n=%0d: got %h expected %h", n, bus_a, BUS_IDLE); end
    end
    n_checks++; if ({dbg_state_a == S_IDLE, busy_a, pio_irq_a} !== 3'b101) begin n_fail++; $display("FAIL disabled_idle: got %b expected 101", {dbg_state_a == S_IDLE, busy_a, pio_irq_a}); end
    enable_a = 1'b1;
    tick();
    n_checks++; if (dbg_state_a !== S_RD_ADDR) begin n_fail++; $display("FAIL enable_start: got %0d expected %0d", dbg_state_a, S_RD_ADDR); end
    n_checks++; if (bus_a !== BUS_RD_DATA) begin n_fail++; $display("FAIL enable_read: got %h expected %h", bus_a, BUS_RD_DATA); end
    repeat (14) tick();
    n_checks++; if ({dbg_state_a == S_IDLE, evt_count_a} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL enable_done: got %h expected %h", {dbg_state_a == S_IDLE, evt_count_a}, {1'b1, 16'd1}); end
    pin_a = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_in_holdoff();
    do_reset();
    enable_a = 1'b1;
    evt_ready_a = 1'b0;
    pin_a = 1'b1;
    repeat (7) tick();
    n_checks++; if ({dbg_state_a == S_HOLDOFF, evt_valid_a} !== 2'b11) begin n_fail++; $display("FAIL pre_abort: got %b expected 11", {dbg_state_a == S_HOLDOFF, evt_valid_a}); end
    reset_n = 1'b0;
    pin_a = 1'b0;
    #2;
    n_checks++; if (bus_a !== BUS_IDLE) begin n_fail++; $display("FAIL abort_bus: got %h expected %h", bus_a, BUS_IDLE); end
    n_checks++; if ({evt_valid_a, evt_level_a, overflow_a, busy_a} !== 4'b0001) begin n_fail++; $display("FAIL abort_flags: got %b expected 0001", {evt_valid_a, evt_level_a, overflow_a, busy_a}); end
    n_checks++; if (evt_count_a !== 16'd0) begin n_fail++; $display("FAIL abort_count: got %0d expected 0", evt_count_a); end
    n_checks++; if (dbg_state_a !== S_INIT_MASK) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", dbg_state_a, S_INIT_MASK); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    n_checks++; if (bus_a !== BUS_WR_MASK) begin n_fail++; $display("FAIL reinit_mask: got %h expected %h", bus_a, BUS_WR_MASK); end
    tick();
    n_checks++; if (bus_a !== BUS_WR_EDGE) begin n_fail++; $display("FAIL reinit_clr: got %h expected %h", bus_a, BUS_WR_EDGE); end
    tick();
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reinit_idle: got %b expected 0", busy_a); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_cnt;
    do_reset();
    exp_cnt = 2'd0;
    for (int p = 0; p < 5; p++) begin
      exp_cnt = exp_cnt + 2'd1;
      exp_q.push_back(exp_cnt);
      pin_b = 1'b1;
      repeat (5) tick();
      n_checks++; if (evt_valid_b !== 1'b1) begin n_fail++; $display("FAIL wrap_valid p=%0d: got %b expected 1", p, evt_valid_b); end
      exp_cnt = exp_q.pop_front();
      n_checks++; if (evt_count_b !== exp_cnt) begin n_fail++; $display("FAIL wrap_count p=%0d: got %0d expected %0d", p, evt_count_b, exp_cnt); end
      pin_b = 1'b0;
      repeat (11) tick();
    end
  endtask

  initial begin
    enable_a = 1'b1; evt_ready_a = 1'b1; pin_a = 1'b0;
    enable_b = 1'b1; evt_ready_b = 1'b1; pin_b = 1'b0;
    repeat (2) tick();
    test_reset();
    test_press_bounce();
    test_overflow();
    test_enable();
    test_reset_in_holdoff();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
